// File: rtl/shift_sequencer_if.sv
// Handshake bundle for shift_sequencer.
//   in_valid/in_ready/in_data/in_amt    : operand + shift amount from producer
//   out_valid/out_ready/out_data        : shifted result to consumer
// master = producer/consumer side, slave = the sequencer.
interface shift_sequencer_if #(
  parameter int unsigned NBITS_DATA = 4,
  parameter int unsigned NBITS_AMT  = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NBITS_DATA-1:0] in_data;
  logic [NBITS_AMT-1:0]  in_amt;
  logic                  out_valid;
  logic                  out_ready;
  logic [NBITS_DATA-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Control stage that drives an external 1-bit arithmetic-shift register stage
// until the requested right shift is complete, then presents the result.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : slave side of shift_sequencer_if (input/output handshakes)
//   busy        : high while shifting or holding a result
//   sh_data     : to register-stage data_in
//   sh_shift    : to register-stage shift
//   sh_result   : from register-stage data_out
// NBITS_DATA/NBITS_AMT must match the interface instance and register stage.
module shift_sequencer #(
  parameter int unsigned NBITS_DATA = 4,
  parameter int unsigned NBITS_AMT  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_sequencer_if.slave      bus,
  output logic                  busy,
  output logic [NBITS_DATA-1:0] sh_data,
  output logic                  sh_shift,
  input  logic [NBITS_DATA-1:0] sh_result
);

  localparam int unsigned CW   = $clog2(NBITS_DATA + 1);
  localparam int unsigned CMPW = (NBITS_AMT > CW) ? NBITS_AMT : CW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] amt_eff;

  // Clamp the amount: anything at or above the width is pure sign fill.
  always_comb begin
    if (CMPW'(bus.in_amt) >= CMPW'(NBITS_DATA)) begin
      amt_eff = CW'(NBITS_DATA);
    end else begin
      amt_eff = CW'(bus.in_amt);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. in_ready is implied by IDLE; reset is handled above.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (amt_eff == '0) begin
            state_next = DONE;
          end else begin
            cnt_next   = amt_eff;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode. In IDLE the register stage tracks in_data so the operand
  // is already loaded on the accept edge; afterwards it feeds back on itself.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    busy          = 1'b0;
    sh_data       = sh_result;
    sh_shift      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = ~reset;
        sh_data      = bus.in_data;
      end
      SHIFT: begin
        sh_shift = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = sh_result;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with a behavioural 1-bit arithmetic-shift
// register stage beside it; results are checked against d >>> min(amt, 4).
module tb_shift_sequencer;

  localparam int unsigned NBITS_DATA = 4;
  localparam int unsigned NBITS_AMT  = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  busy;
  logic [NBITS_DATA-1:0] sh_data;
  logic                  sh_shift;
  logic [NBITS_DATA-1:0] sh_result;

  int n_checks = 0;
  int n_pass   = 0;

  shift_sequencer_if #(.NBITS_DATA(NBITS_DATA), .NBITS_AMT(NBITS_AMT)) bus ();

  shift_sequencer #(.NBITS_DATA(NBITS_DATA), .NBITS_AMT(NBITS_AMT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .sh_data   (sh_data),
    .sh_shift  (sh_shift),
    .sh_result (sh_result)
  );

  always #5 clk = ~clk;

  // Register stage: load data_in, or load data_in shifted right by one with sign fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_result <= '0;
    end else if (sh_shift) begin
      sh_result <= {sh_data[NBITS_DATA-1], sh_data[NBITS_DATA-1:1]};
    end else begin
      sh_result <= sh_data;
    end
  end

  function automatic logic [3:0] ref_shift(input logic [3:0] d, input int amt);
    logic signed [3:0] s;
    int a;
    s = d;
    a = (amt > 4) ? 4 : amt;
    return s >>> a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    check("wait_idle", 32'(bus.in_ready), 32'd1);
  endtask

  // Waits for out_valid from cycle 1 after accept; returns latency and shift-cycle count.
  task automatic wait_result(output int lat, output int shifts, output bit quiet_ok);
    lat      = 1;
    shifts   = 0;
    quiet_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      if (sh_shift === 1'b1) shifts++;
      if (bus.out_data !== 4'd0 || busy !== 1'b1 || bus.in_ready !== 1'b0) quiet_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic run_op(input logic [3:0] d, input int amt, input int hold);
    logic [3:0] exp;
    int ae, lat, shifts;
    bit quiet_ok, stable;
    exp = ref_shift(d, amt);
    ae  = (amt > 4) ? 4 : amt;
    wait_idle();
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = 3'(amt);
    bus.out_ready = 1'b0;
    #1;
    check("sh_data_track", 32'(sh_data), 32'(d));
    step();
    bus.in_valid = 1'b0;
    wait_result(lat, shifts, quiet_ok);
    check("latency", 32'(lat), 32'(ae + 1));
    check("shift_cycles", 32'(shifts), 32'(ae));
    check("quiet_while_shifting", 32'(quiet_ok), 32'd1);
    check("out_data", 32'(bus.out_data), 32'(exp));
    check("busy_done", 32'(busy), 32'd1);
    check("in_ready_done", 32'(bus.in_ready), 32'd0);
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        step();
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp ||
            bus.in_ready !== 1'b0 || sh_shift !== 1'b0) stable = 1'b0;
      end
      check("hold_stable", 32'(stable), 32'd1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_out_data", 32'(bus.out_data), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat, shifts;
    bit quiet_ok, no_pulse;
    logic [3:0] rd;
    int ra, rh;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_sh_result", 32'(sh_result), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases.
    run_op(4'b1000, 2, 0);
    run_op(4'b0110, 1, 0);
    run_op(4'b1011, 0, 0);
    run_op(4'b1001, 7, 0);
    run_op(4'b0101, 7, 0);
    run_op(4'b0111, 4, 0);
    run_op(4'b1000, 2, 6);

    // in_valid held across the DONE exit edge must not be taken on that edge.
    wait_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1010;
    bus.in_amt   = 3'd1;
    step();
    bus.in_valid = 1'b0;
    wait_result(lat, shifts, quiet_ok);
    check("exit_first_data", 32'(bus.out_data), 32'(ref_shift(4'b1010, 1)));
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0100;
    bus.in_amt    = 3'd2;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("exit_not_accepted", 32'(busy), 32'd0);
    check("exit_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("exit_next_accept", 32'(busy), 32'd1);
    wait_result(lat, shifts, quiet_ok);
    check("exit_second_lat", 32'(lat), 32'd3);
    check("exit_second_data", 32'(bus.out_data), 32'(ref_shift(4'b0100, 2)));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Reset in the middle of a shift discards the operation.
    wait_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0111;
    bus.in_amt   = 3'd3;
    step();
    bus.in_valid = 1'b0;
    step();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_shift", 32'(sh_shift), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sh_result", 32'(sh_result), 32'd0);
    check("mid_rst_in_ready_after", 32'(bus.in_ready), 32'd1);
    no_pulse = 1'b1;
    repeat (8) begin
      step();
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) no_pulse = 1'b0;
    end
    check("mid_rst_no_pulse", 32'(no_pulse), 32'd1);
    run_op(4'b1100, 1, 0);

    // Randomized operations against the reference.
    for (int i = 0; i < 24; i++) begin
      rd = 4'($urandom);
      ra = int'($urandom_range(0, 7));
      rh = int'($urandom_range(0, 3));
      run_op(rd, ra, rh);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
